fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares the single write port of the asynchronous FIFO (`w_en`/`datain`, `full`) among `NUM_REQ` producers in the write-clock domain. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst, gates every write against `full`, and never issues a write while the FIFO is full. It sits directly in front of the FIFO's write side.

---
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ valid/ready producers.
// The owner keeps the port for up to BURST_MAX words; every write is gated by full.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 4,
    parameter int IDW        = $clog2(NUM_REQ)
) (
    input  logic                          wrclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         datain,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy,
    output logic [15:0]                   wr_count
);

    // Handshake: a producer word moves on the rising edge where req_valid[i] and
    // req_ready[i] are both high; a producer holds its data while valid && !ready.
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [IDW-1:0] LAST_IDX   = IDW'(NUM_REQ - 1);
    localparam logic [3:0]     BURST_LAST = 4'(BURST_MAX - 1);

    state_t          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [3:0]      beats_q, beats_d;
    logic [15:0]     wr_count_q, wr_count_d;

    logic            owner_valid;
    logic            xfer;
    logic            pick_found;
    logic [IDW-1:0]  pick;
    logic [IDW-1:0]  owner_plus1;

    assign owner_valid = req_valid[owner_q];
    assign xfer        = (state_q == GRANT) && owner_valid && !full;
    assign w_en        = xfer;
    assign datain      = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_id    = owner_q;
    assign busy        = (state_q == GRANT);
    assign wr_count    = wr_count_q;

    // Explicit compare so non power-of-two NUM_REQ wraps correctly.
    assign owner_plus1 = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    always_comb begin
        req_ready = '0;
        if ((state_q == GRANT) && !full) begin
            req_ready[owner_q] = 1'b1;
        end
    end

    // First valid requester at or after rr_q, searching modulo NUM_REQ.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_v;
        pick       = '0;
        pick_found = 1'b0;
        idx        = 0;
        idx_v      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_v = IDW'(idx);
            if (!pick_found && req_valid[idx_v]) begin
                pick       = idx_v;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        beats_d    = beats_q;
        wr_count_d = wr_count_q + 16'(xfer);
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    owner_d = pick;
                    beats_d = '0;
                end
            end
            GRANT: begin
                if ((xfer && (beats_q == BURST_LAST)) || !owner_valid) begin
                    state_d = IDLE;
                    rr_d    = owner_plus1;
                    beats_d = '0;
                end else if (xfer) begin
                    beats_d = beats_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wrclk or posedge wrst) begin
        if (wrst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_q       <= '0;
            beats_q    <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            beats_q    <= beats_d;
            wr_count_q <= wr_count_d;
        end
    end

endmodule
